// File: rtl/mac_stream_acc_pkg.sv
// ============================================================================
//  Module      : mac_stream_acc_pkg
//  Description : Shared constants and the saturation-limit helper for the
//                streaming multiply-accumulate engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mac_stream_acc_pkg;

    // Overflow handling modes.
    localparam bit OVF_WRAP     = 1'b0;
    localparam bit OVF_SATURATE = 1'b1;

    // Operand / accumulator interpretation.
    localparam bit OPS_UNSIGNED = 1'b0;
    localparam bit OPS_SIGNED   = 1'b1;

    // Widest accumulator the limit helper can describe.
    localparam int unsigned LIM_W = 64;

    // Largest (negative=0) or smallest (negative=1) value representable in
    // 'width' bits, returned right-aligned in a LIM_W vector. The unsigned
    // minimum is never needed because an unsigned sum cannot underflow.
    function automatic logic [LIM_W-1:0] sat_limit(input int unsigned width,
                                                  input bit          is_signed,
                                                  input bit          negative);
        logic [LIM_W-1:0] ones;
        logic [LIM_W-1:0] half;
        ones = (64'd1 << width) - 64'd1;
        half = 64'd1 << (width - 1);
        if (!is_signed) begin
            return negative ? '0 : ones;
        end
        return negative ? half : (half - 64'd1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mac_stream_acc_if.sv
// ============================================================================
//  Module      : mac_stream_acc_if
//  Description : Operand-beat and result handshakes of the MAC engine.
//                master = producer/consumer side, slave = engine side.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mac_stream_acc_if #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_acc;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_acc, out_ovf, out_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_acc, out_ovf, out_count
    );
endinterface

`default_nettype wire

// File: rtl/mac_stream_acc_mul_stage.sv
// ============================================================================
//  Module      : mac_stream_acc_mul_stage
//  Description : Stage-1 product register. Captures a*b (signed or unsigned)
//                and the last flag of an accepted beat; holds while stalled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_stream_acc_mul_stage
    import mac_stream_acc_pkg::*;
#(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter bit SIGNED = OPS_UNSIGNED
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               flush_i,
    input  wire logic               en_i,
    input  wire logic               fire_i,
    input  wire logic [A_W-1:0]     a_i,
    input  wire logic [B_W-1:0]     b_i,
    input  wire logic               last_i,
    output logic                    valid_o,
    output logic                    last_o,
    output logic [A_W+B_W-1:0]      prod_o
);

    localparam int P_W = A_W + B_W;

    logic [P_W-1:0] w_a_ext;
    logic [P_W-1:0] w_b_ext;
    logic [P_W-1:0] w_prod;
    logic           valid_q;
    logic           last_q;
    logic [P_W-1:0] prod_q;

    // Extending both operands to the full product width makes the low P_W
    // bits of an unsigned multiply equal to the exact signed product.
    generate
        if (SIGNED) begin : g_signed
            assign w_a_ext = {{B_W{a_i[A_W-1]}}, a_i};
            assign w_b_ext = {{A_W{b_i[B_W-1]}}, b_i};
        end else begin : g_unsigned
            assign w_a_ext = {{B_W{1'b0}}, a_i};
            assign w_b_ext = {{A_W{1'b0}}, b_i};
        end
    endgenerate

    assign w_prod = w_a_ext * w_b_ext;

    // Stage register: a flush empties it, but a beat accepted in the same
    // cycle still lands; while stalled (en_i=0) the contents are held.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            prod_q  <= '0;
        end else if (flush_i || en_i) begin
            valid_q <= fire_i;
            if (fire_i) begin
                prod_q <= w_prod;
                last_q <= last_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign prod_o  = prod_q;

endmodule

`default_nettype wire

// File: rtl/mac_stream_acc.sv
// ============================================================================
//  Module      : mac_stream_acc
//  Description : Streaming multiply-accumulate engine. Accumulates stage-1
//                products, detects/saturates overflow, counts terms and
//                hands each closed dot product to a held output register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_stream_acc
    import mac_stream_acc_pkg::*;
#(
    parameter int A_W      = 8,
    parameter int B_W      = 8,
    parameter int ACC_W    = 24,
    parameter int CNT_W    = 8,
    parameter bit SIGNED   = OPS_UNSIGNED,
    parameter bit SATURATE = OVF_SATURATE
) (
    input  wire logic               clk,
    input  wire logic               rst,
    mac_stream_acc_if.slave         bus,
    input  wire logic               clear_i,
    input  wire logic               acc_load_i,
    input  wire logic [ACC_W-1:0]   load_val_i,
    output logic [ACC_W-1:0]        acc_now_o
);

    localparam int P_W = A_W + B_W;
    localparam logic [ACC_W-1:0] C_POS_LIM = ACC_W'(sat_limit(ACC_W, SIGNED, 1'b0));
    localparam logic [ACC_W-1:0] C_NEG_LIM = ACC_W'(sat_limit(ACC_W, SIGNED, 1'b1));

    logic             w_stall;
    logic             w_fire;
    logic             w_adv;
    logic             w_new_res;
    logic             w_s1_valid;
    logic             w_s1_last;
    logic [P_W-1:0]   w_s1_prod;
    logic [ACC_W-1:0] w_prod_ext;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W-1:0] w_addend;
    logic [ACC_W:0]   w_sum;
    logic             w_ovf;
    logic [ACC_W-1:0] w_lim;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] count_q;
    logic             sticky_q;
    logic             out_valid_q;
    logic [ACC_W-1:0] out_acc_q;
    logic             out_ovf_q;
    logic [CNT_W-1:0] out_count_q;

    // A finished dot product waiting in stage 1 cannot move while the
    // previous result is still unclaimed; everything upstream freezes.
    assign w_stall    = w_s1_valid & w_s1_last & out_valid_q & ~bus.out_ready;
    assign w_fire     = bus.in_valid & ~w_stall;
    assign w_adv      = w_s1_valid & ~w_stall;
    assign w_new_res  = w_adv & w_s1_last & ~clear_i;

    mac_stream_acc_mul_stage #(
        .A_W    (A_W),
        .B_W    (B_W),
        .SIGNED (SIGNED)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .flush_i (clear_i),
        .en_i    (~w_stall),
        .fire_i  (w_fire),
        .a_i     (bus.in_a),
        .b_i     (bus.in_b),
        .last_i  (bus.in_last),
        .valid_o (w_s1_valid),
        .last_o  (w_s1_last),
        .prod_o  (w_s1_prod)
    );

    generate
        if (SIGNED) begin : g_ext_signed
            assign w_prod_ext = ACC_W'($signed(w_s1_prod));
        end else begin : g_ext_unsigned
            assign w_prod_ext = ACC_W'(w_s1_prod);
        end
    endgenerate

    // Next accumulator value: base (live or loaded) plus the advancing
    // product, with overflow detection and optional clamping.
    always_comb begin
        w_base   = acc_load_i ? load_val_i : acc_q;
        w_addend = w_adv ? w_prod_ext : '0;
        w_sum    = {1'b0, w_base} + {1'b0, w_addend};
        w_ovf    = 1'b0;
        w_lim    = C_POS_LIM;
        if (SIGNED) begin
            w_ovf = (w_base[ACC_W-1] == w_addend[ACC_W-1]) &&
                    (w_sum[ACC_W-1] != w_base[ACC_W-1]);
            w_lim = w_base[ACC_W-1] ? C_NEG_LIM : C_POS_LIM;
        end else begin
            w_ovf = w_sum[ACC_W];
        end
        acc_d = (w_ovf && SATURATE) ? w_lim : w_sum[ACC_W-1:0];
    end

    // Accumulator, term counter and sticky overflow; a closing beat
    // restarts all three for the next dot product.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else if (clear_i) begin
            acc_q    <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else if (w_adv && w_s1_last) begin
            acc_q    <= '0;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else if (acc_load_i) begin
            acc_q    <= acc_d;
        end else if (w_adv) begin
            acc_q    <= acc_d;
            count_q  <= count_q + CNT_W'(1);
            sticky_q <= sticky_q | w_ovf;
        end
    end

    // Result register: a new result overwrites (even when the old one is
    // consumed in the same cycle); otherwise valid drops once taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_count_q <= '0;
        end else if (w_new_res) begin
            out_valid_q <= 1'b1;
            out_acc_q   <= acc_d;
            out_ovf_q   <= sticky_q | w_ovf;
            out_count_q <= count_q + CNT_W'(1);
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = out_valid_q;
    assign bus.out_acc   = out_acc_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_count = out_count_q;
    assign acc_now_o     = acc_q;

endmodule

`default_nettype wire
